// File: rtl/load_store_unit_if.sv
// Request/response bundle between the memory-access stage and the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_size;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword load-store sequencer in front of a 256x8 data memory.
// Halfwords are split into two byte accesses at addr and addr+1 (wrapping).
module load_store_unit (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   lsu,
  output logic [7:0]         o_mem_address,
  output logic [7:0]         o_mem_write_data,
  output logic               o_mem_wren,
  input  logic [7:0]         i_mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_write;
  logic        r_size;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata_hi;
  logic [15:0] r_rdata;

  logic [7:0]  r_mem_address;
  logic [7:0]  r_mem_write_data;
  logic        r_mem_wren;
  logic        r_req_ready;
  logic        r_resp_valid;

  logic [7:0]  w_mem_address_nxt;
  logic [7:0]  w_mem_write_data_nxt;
  logic        w_mem_wren_nxt;
  logic        w_req_ready_nxt;
  logic        w_resp_valid_nxt;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (lsu.req_valid) begin
          w_state_nxt = BYTE0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BYTE0: begin
        if (r_size) begin
          w_state_nxt = BYTE1;
        end else begin
          w_state_nxt = RESP;
        end
      end
      BYTE1:   w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output values for the upcoming state; every output is a register.
  // BYTE0 is only entered from IDLE, so its address/data come from the request being accepted.
  always_comb begin
    w_mem_address_nxt    = r_mem_address;
    w_mem_write_data_nxt = 8'h00;
    w_mem_wren_nxt       = 1'b1;
    w_req_ready_nxt      = 1'b0;
    w_resp_valid_nxt     = 1'b0;
    case (w_state_nxt)
      IDLE: begin
        w_req_ready_nxt = 1'b1;
      end
      BYTE0: begin
        w_mem_address_nxt = lsu.req_addr;
        if (lsu.req_write) begin
          w_mem_write_data_nxt = lsu.req_wdata[7:0];
          w_mem_wren_nxt       = 1'b0;
        end else begin
          w_mem_write_data_nxt = 8'h00;
          w_mem_wren_nxt       = 1'b1;
        end
      end
      BYTE1: begin
        w_mem_address_nxt = r_addr + 8'd1;
        if (r_write) begin
          w_mem_write_data_nxt = r_wdata_hi;
          w_mem_wren_nxt       = 1'b0;
        end else begin
          w_mem_write_data_nxt = 8'h00;
          w_mem_wren_nxt       = 1'b1;
        end
      end
      RESP: begin
        w_resp_valid_nxt = 1'b1;
      end
      default: begin
        w_req_ready_nxt = 1'b0;
      end
    endcase
  end

  // State, request capture, load-data capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_write          <= 1'b0;
      r_size           <= 1'b0;
      r_addr           <= 8'h00;
      r_wdata_hi       <= 8'h00;
      r_rdata          <= 16'h0000;
      r_mem_address    <= 8'h00;
      r_mem_write_data <= 8'h00;
      r_mem_wren       <= 1'b1;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_mem_address    <= w_mem_address_nxt;
      r_mem_write_data <= w_mem_write_data_nxt;
      r_mem_wren       <= w_mem_wren_nxt;
      r_req_ready      <= w_req_ready_nxt;
      r_resp_valid     <= w_resp_valid_nxt;
      case (r_state)
        IDLE: begin
          if (lsu.req_valid) begin
            r_write    <= lsu.req_write;
            r_size     <= lsu.req_size;
            r_addr     <= lsu.req_addr;
            r_wdata_hi <= lsu.req_wdata[15:8];
            r_rdata    <= 16'h0000;
          end else begin
            r_rdata    <= r_rdata;
          end
        end
        BYTE0: begin
          if (!r_write) begin
            r_rdata[7:0] <= i_mem_read_data;
          end else begin
            r_rdata      <= r_rdata;
          end
        end
        BYTE1: begin
          if (!r_write) begin
            r_rdata[15:8] <= i_mem_read_data;
          end else begin
            r_rdata       <= r_rdata;
          end
        end
        default: begin
          r_rdata <= r_rdata;
        end
      endcase
    end
  end

  assign lsu.req_ready     = r_req_ready;
  assign lsu.resp_valid    = r_resp_valid;
  assign lsu.resp_rdata    = r_rdata;
  assign o_mem_address     = r_mem_address;
  assign o_mem_write_data  = r_mem_write_data;
  assign o_mem_wren        = r_mem_wren;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 256x8 memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;
  logic [7:0]  mem_address;
  logic [7:0]  mem_write_data;
  logic        mem_wren;
  logic [7:0]  mem_read_data;
  logic [7:0]  mem [0:255];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wren_lows = 0;

  logic [15:0] exp_q [$];
  int          cyc_q [$];

  always #5 clk = ~clk;

  load_store_unit_if lsu ();

  load_store_unit dut (
    .clk              (clk),
    .rst              (rst),
    .lsu              (lsu),
    .o_mem_address    (mem_address),
    .o_mem_write_data (mem_write_data),
    .o_mem_wren       (mem_wren),
    .i_mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem[mem_address];

  // Memory model: write on posedge when wren is low; count write cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hC3;
    end else if (mem_wren === 1'b0) begin
      mem[mem_address] <= mem_write_data;
      wren_lows <= wren_lows + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every response pulse.
  always @(negedge clk) begin
    if (lsu.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got rdata %h at cycle %0d, expected no response", lsu.resp_rdata, cyc);
      end else begin
        chk("resp_rdata", lsu.resp_rdata, exp_q.pop_front());
        chk("resp_cycle", cyc, cyc_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (lsu.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", lsu.req_ready, 1);
  endtask

  task automatic drive(input logic w, input logic s, input logic [7:0] a, input logic [15:0] d);
    lsu.req_valid = 1'b1;
    lsu.req_write = w;
    lsu.req_size  = s;
    lsu.req_addr  = a;
    lsu.req_wdata = d;
  endtask

  task automatic do_req(input logic w, input logic s, input logic [7:0] a,
                        input logic [15:0] d, input logic [15:0] e);
    wait_ready();
    drive(w, s, a, d);
    exp_q.push_back(e);
    cyc_q.push_back(cyc + (s ? 3 : 2));
    @(negedge clk);
    lsu.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    mem_init = 1'b1;
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'h00, 16'hFFFF);
    repeat (2) @(negedge clk);
    chk("rst_ready", lsu.req_ready, 1);
    chk("rst_resp_valid", lsu.resp_valid, 0);
    chk("rst_resp_rdata", lsu.resp_rdata, 16'h0000);
    chk("rst_addr", mem_address, 8'h00);
    chk("rst_wdata", mem_write_data, 8'h00);
    chk("rst_wren", mem_wren, 1);
    mem_init = 1'b0;
    rst = 1'b0;
    lsu.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_write", wren_lows, 0);
    chk("rst_release_ready", lsu.req_ready, 1);

    // Byte store then byte load.
    w0 = wren_lows;
    do_req(1'b1, 1'b0, 8'h00, 16'h0021, 16'h0000);
    drain();
    chk("bstore_wren_cycles", wren_lows - w0, 1);
    chk("bstore_mem0", mem[0], 8'h21);
    w0 = wren_lows;
    do_req(1'b0, 1'b0, 8'h00, 16'hDEAD, 16'h0021);
    drain();
    chk("bload_no_write", wren_lows - w0, 0);

    // Halfword store then halfword load.
    w0 = wren_lows;
    do_req(1'b1, 1'b1, 8'h02, 16'hA987, 16'h0000);
    drain();
    chk("hstore_wren_cycles", wren_lows - w0, 2);
    chk("hstore_mem2", mem[2], 8'h87);
    chk("hstore_mem3", mem[3], 8'hA9);
    do_req(1'b0, 1'b1, 8'h02, 16'h0000, 16'hA987);
    drain();

    // Address wrap at 0xFF.
    do_req(1'b1, 1'b1, 8'hFF, 16'h4321, 16'h0000);
    drain();
    chk("wrap_memFF", mem[255], 8'h21);
    chk("wrap_mem00", mem[0], 8'h43);
    do_req(1'b0, 1'b1, 8'hFF, 16'h0000, 16'h4321);
    do_req(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0043);
    drain();

    // Busy: request held and changed while an op is in flight.
    w0 = wren_lows;
    wait_ready();
    drive(1'b1, 1'b1, 8'h40, 16'h1234);
    exp_q.push_back(16'h0000);
    cyc_q.push_back(cyc + 3);
    @(negedge clk);
    chk("busy_ready_b0", lsu.req_ready, 0);
    lsu.req_addr  = 8'h50;
    lsu.req_wdata = 16'h5678;
    @(negedge clk);
    chk("busy_ready_b1", lsu.req_ready, 0);
    @(negedge clk);
    chk("busy_ready_resp", lsu.req_ready, 0);
    @(negedge clk);
    chk("busy_ready_idle", lsu.req_ready, 1);
    exp_q.push_back(16'h0000);
    cyc_q.push_back(cyc + 3);
    @(negedge clk);
    lsu.req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("busy_mem40", mem[8'h40], 8'h34);
    chk("busy_mem41", mem[8'h41], 8'h12);
    chk("busy_mem50", mem[8'h50], 8'h78);
    chk("busy_mem51", mem[8'h51], 8'h56);
    chk("busy_wren_cycles", wren_lows - w0, 4);

    // Reset during a halfword store, sampled at the edge closing BYTE0.
    w0 = wren_lows;
    wait_ready();
    drive(1'b1, 1'b1, 8'h10, 16'hBEEF);
    @(negedge clk);
    lsu.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_wren", mem_wren, 1);
    chk("abort_resp_valid", lsu.resp_valid, 0);
    chk("abort_ready", lsu.req_ready, 1);
    repeat (4) @(negedge clk);
    chk("abort_mem10", mem[8'h10], 8'hEF);
    chk("abort_mem11", mem[8'h11], 8'hC3);
    chk("abort_wren_cycles", wren_lows - w0, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
